// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Shares the write side of one strobe-interface FIFO (d_in, d_in_strobe, full)
// among N producers. Arbitration is round-robin starting after the last winner.
// Each grant produces a registered one-cycle strobe and ack, then one gap cycle
// so the FIFO's full flag reflects the write before the next arbitration:
//   IDLE -> WRITE -> GAP -> IDLE
// Build option: define FIFO_ARB_PRIORITY_EN to give producer 0 absolute
// priority; producers 1..N-1 then round-robin among themselves.
// Handshake: req[i] is a level; producer i holds req[i] and its data word
// stable until ack[i] pulses. ack[i] and d_in_strobe are coincident one-cycle
// pulses. A req[i] still high in the cycle after ack[i] is a new request.
// The FSM state is exported on dbg_state_o for observation.
module fifo_wr_arbiter #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int IDW   = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   data,
    output logic [N-1:0]         ack,
    input  logic                 full,
    output logic [WIDTH-1:0]     d_in,
    output logic                 d_in_strobe,
    output logic [IDW-1:0]       grant_id,
    output logic                 busy,
    output logic [1:0]           dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        GAP   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] d_in_q, d_in_d;
    logic             strobe_q, strobe_d;
    logic [N-1:0]     ack_q, ack_d;
    logic [IDW-1:0]   grant_q, grant_d;
    logic [IDW-1:0]   last_q, last_d;

    logic [WIDTH-1:0] data_arr [N];
    logic             sel_found;
    logic [IDW-1:0]   sel_idx;
    logic [IDW-1:0]   cand;

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign data_arr[g] = data[g*WIDTH +: WIDTH];
    end

    // Find the first requester in rotation order after the last winner.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
`ifdef FIFO_ARB_PRIORITY_EN
        if (req[0]) begin
            sel_found = 1'b1;
        end else begin
            // last_q only ever holds 1..N-1 here, so the walk covers 1..N-1.
            for (int k = 1; k < N; k++) begin
                cand = IDW'(((32'(last_q) - 32'd1 + 32'(k)) % 32'(N - 1)) + 32'd1);
                if (!sel_found && req[cand]) begin
                    sel_found = 1'b1;
                    sel_idx   = cand;
                end
            end
        end
`else
        for (int k = 1; k <= N; k++) begin
            cand = IDW'((32'(last_q) + 32'(k)) % 32'(N));
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
`endif
    end

    // Next-state and registered-output logic for IDLE -> WRITE -> GAP.
    always_comb begin
        state_d  = state_q;
        d_in_d   = d_in_q;
        strobe_d = 1'b0;
        ack_d    = '0;
        grant_d  = grant_q;
        last_d   = last_q;
        case (state_q)
            IDLE: begin
                // An X/Z full does not compare equal to 0, so no grant is made.
                if (sel_found && (full == 1'b0)) begin
                    d_in_d   = data_arr[sel_idx];
                    strobe_d = 1'b1;
                    ack_d    = N'(1) << sel_idx;
                    grant_d  = sel_idx;
`ifdef FIFO_ARB_PRIORITY_EN
                    // Producer 0 wins outside the rotation and leaves it untouched.
                    if (sel_idx != '0) begin
                        last_d = sel_idx;
                    end
`else
                    last_d   = sel_idx;
`endif
                    state_d  = WRITE;
                end
            end
            WRITE:   state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset clears them without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            d_in_q   <= '0;
            strobe_q <= 1'b0;
            ack_q    <= '0;
            grant_q  <= '0;
            last_q   <= IDW'(N - 1);
        end else begin
            state_q  <= state_d;
            d_in_q   <= d_in_d;
            strobe_q <= strobe_d;
            ack_q    <= ack_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
        end
    end

    assign d_in        = d_in_q;
    assign d_in_strobe = strobe_q;
    assign ack         = ack_q;
    assign grant_id    = grant_q;
    assign busy        = (state_q != IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares one strobe-interface FIFO (WIDTH-bit `d_in`, `d_in_strobe`, `full`) between N independent producers. It sits between the producer processes and the FIFO's write side. It selects one requesting producer, presents that producer's word with a single-cycle write strobe, and acknowledges it. It never strobes while the FIFO reports full.

## Interface
Parameters:
- `WIDTH`, 8: data word width; must match the FIFO.
- `N`, 4: number of producers; N >= 2.
- `IDW`, `$clog2(N)`: width of `grant_id`.

Ports:
- `clk` in 1: clock; all state changes on posedge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req` in N: per-producer write request; level.
- `data` in N*WIDTH: producer words; producer i occupies bits [i*WIDTH +: WIDTH].
- `ack` out N: one-cycle pulse to the granted producer; its word is being written.
- `full` in 1: FIFO full flag.
- `d_in` out WIDTH: FIFO write data (registered).
- `d_in_strobe` out 1: FIFO write strobe (registered, one cycle high per write).
- `grant_id` out IDW: index of the most recently granted producer.
- `busy` out 1: high whenever state != IDLE.

## Operation
- Reset values: `d_in`=0, `d_in_strobe`=0, `ack`=0, `grant_id`=0, `busy`=0, state=IDLE. Round-robin pointer `last`=N-1, so producer 0 wins the first arbitration.
- States are IDLE → WRITE → GAP → IDLE.
- IDLE: at a posedge with `|req` and `full===1'b0`:
  - sel = first i with req[i], searching last+1, last+2, … mod N (wraps at N-1 → 0).
  - Register `d_in`<=data[sel], `d_in_strobe`<=1, `ack[sel]`<=1, `grant_id`<=sel, `last`<=sel.
  - Go to WRITE.
- IDLE with `full` high, X, or Z: no grant; state held; `req` remains pending.
- WRITE: next posedge `d_in_strobe`<=0, `ack`<=0, go to GAP. `d_in` holds its value.
- GAP: one idle cycle so the FIFO's `full` can reflect the write. Next posedge go to IDLE. No sampling of `req` or `full` in GAP.
- Producer contract:
  - Hold `req[i]` and its data stable until `ack[i]` is seen.
  - Deassert `req[i]` no later than the posedge after `ack[i]`, unless it has another word.
  - A held `req[i]` after ack counts as a new request.
- Simultaneous requests: exactly one grant per arbitration. Losers keep `req` high and are guaranteed service within N arbitrations.
- Requests that rise while in WRITE or GAP are considered at the next IDLE evaluation.
- Reset asserted mid-operation:
  - All outputs clear immediately (asynchronously), state→IDLE, `last`→N-1.
  - A strobe cut short by reset may or may not have been taken by the FIFO; the system resets both together.

## Timing
- Latency: `req` high at posedge k in IDLE with FIFO not full gives `d_in_strobe`/`ack` high for the cycle k..k+1.
- Peak throughput: one write per 3 clocks (strobes at edges k, k+3, k+6…).
- `ack` and `d_in_strobe` are always coincident, one cycle wide, and never asserted for more than one producer.
- `full` is sampled only at IDLE posedges. A FIFO with one free slot is written once, then `full` is rechecked before any further strobe.

## Configuration
- `FIFO_ARB_PRIORITY_EN` defined: producer 0 has absolute priority. If `req[0]` is high in IDLE, it wins regardless of `last`. Producers 1..N-1 round-robin among themselves; `last` is updated only by their grants.
- `FIFO_ARB_PRIORITY_EN` not defined: pure round-robin over all N producers as above.

## Test plan
- Reset/first grant: release `rst_n`; all outputs read 0. Raise req[0] and req[2] (data 0x11/0x33) together → strobe with `d_in`=0x11, ack[0], grant_id=0; 3 clocks later strobe with 0x33, ack[2], grant_id=2.
- Rotation: all 4 producers request continuously with fresh words and drop/re-raise on ack → grant_id sequence 0,1,2,3,0,1…; strobes exactly 3 clocks apart; `busy` low only in IDLE.
- Full back-pressure: `full`=1 with req[1] high, data 0xA5, for 10 clocks → no strobe, no ack. Drop `full` → at the next posedge, strobe with `d_in`=0xA5 and ack[1] for one cycle.
- Reset mid-write: assert `rst_n` low during WRITE → `d_in_strobe`, `ack`, `busy` fall without waiting for a clock edge. After release, the next grant goes to producer 0 if it is requesting.
- Priority macro: req[0] and req[1] held high → with `FIFO_ARB_PRIORITY_EN`, every grant goes to 0; without it, grants alternate 0,1,0,1.
- Integration: 4 producers each send 0..63 with random 1–15 ns skew into a 5-deep WIDTH=8 FIFO drained by a random-rate consumer → all 256 words arrive; per-producer order is preserved; no duplicates; completes before a 256*500 time-unit timeout.
